// File: rtl/instr_encoder_loader_if.sv
// Request stream plus instruction-memory write port of the encoder/loader.
// Latency: none, wiring only.
// Backpressure: in_ready throttles requests, mem_ready throttles writes.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  // field-level instruction request stream
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [2:0]        in_dr;
  logic [2:0]        in_sr1;
  logic [2:0]        in_sr2;
  logic              in_imm_mode;
  logic [4:0]        in_imm5;
  logic [2:0]        in_nzp;
  logic [8:0]        in_off9;
  logic              in_last;
  // instruction-memory write port
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  // loader side
  modport slave (
    input  in_valid, in_op, in_dr, in_sr1, in_sr2, in_imm_mode, in_imm5,
           in_nzp, in_off9, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // request source / memory side
  modport master (
    output in_valid, in_op, in_dr, in_sr1, in_sr2, in_imm_mode, in_imm5,
           in_nzp, in_off9, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes field-level instruction requests into 16-bit words and writes them to consecutive addresses.
// Latency: a word accepted in cycle t is presented on mem_we/mem_wdata from cycle t+1 (registered FIFO, no bypass).
// Backpressure: in_ready = !fifo_full while loading; mem_ready=0 holds mem_addr/mem_wdata stable.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fcnt_q;
  logic [ADDR_W-1:0] addr_q, count_q;
  logic              err_q;

  logic        fifo_empty, fifo_full;
  logic        in_ready_c, busy_c, done_c;
  logic        accept, legal, push, pop;
  logic [15:0] word;

  // Field-to-word encoding; ops 6 and 7 produce no word and are filtered by 'legal'.
  function automatic logic [15:0] encode(
    input logic [2:0] op,
    input logic [2:0] dr,
    input logic [2:0] sr1,
    input logic [2:0] sr2,
    input logic       imm_mode,
    input logic [4:0] imm5,
    input logic [2:0] nzp,
    input logic [8:0] off9
  );
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      3'd0:    w = {4'b0001, dr, sr1, imm_mode, imm_mode ? imm5 : {2'b00, sr2}};
      3'd1:    w = {4'b0101, dr, sr1, imm_mode, imm_mode ? imm5 : {2'b00, sr2}};
      3'd2:    w = {4'b1001, dr, sr1, 6'b111111};
      3'd3:    w = {4'b0000, nzp, off9};
      3'd4:    w = {4'b1100, 3'b000, sr1, 6'b000000};
      3'd5:    w = {4'b1110, dr, off9};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
  assign legal      = (bus.in_op <= 3'd5);
  // Full alone gates input, so a pop in the same cycle does not reopen a full FIFO.
  assign accept     = (state_q == S_RUN) && bus.in_valid && !fifo_full;
  assign push       = accept && legal;
  assign pop        = !fifo_empty && bus.mem_ready;
  assign word       = encode(bus.in_op, bus.in_dr, bus.in_sr1, bus.in_sr2,
                             bus.in_imm_mode, bus.in_imm5, bus.in_nzp, bus.in_off9);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        in_ready_c = !fifo_full;
        if (bus.in_valid && !fifo_full && bus.in_last) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers/occupancy, write address, word count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        addr_q   <= addr_q + ADDR_W'(1);
        count_q  <= count_q + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + CNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - CNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      if (accept && !legal) err_q <= 1'b1;
      // FIFO is always empty in IDLE, so start never races a pop
      if ((state_q == S_IDLE) && start) begin
        addr_q  <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Word storage; stale entries are harmless because reset clears the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= word;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = fifo_empty ? 16'h0000 : fifo_q[rd_ptr_q];
  assign busy          = busy_c;
  assign done          = done_c;
  assign err           = err_q;
  assign count         = count_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: encoding table plus load sequences.
// Latency: expected writes queued at request acceptance, compared when the write handshakes.
// Backpressure: exercised with held-off and randomised mem_ready.
module tb_instr_encoder_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, err;
  logic [7:0] count;

  instr_encoder_loader_if #(.ADDR_W(8)) bus ();

  instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_mode;
    logic [4:0]  imm5;
    logic [2:0]  nzp;
    logic [8:0]  off9;
    logic [15:0] word;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  vec_t       vecs [12];
  vec_t       bad6, bad7;
  wr_t        sb_q [$];
  wr_t        exp_wr;
  logic [7:0] exp_addr = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       stop_rand;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [15:0] prev_data = 16'h0000;

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] dr, input logic [2:0] sr1,
                              input logic [2:0] sr2, input logic im, input logic [4:0] i5,
                              input logic [2:0] nzp, input logic [8:0] off, input logic [15:0] w);
    vec_t v;
    v = '{op, dr, sr1, sr2, im, i5, nzp, off, w};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every write handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      if (prev_stall) begin
        check("stall_addr_hold", 32'(bus.mem_addr), 32'(prev_addr));
        check("stall_data_hold", 32'(bus.mem_wdata), 32'(prev_data));
      end
      if (bus.mem_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got write 0x%0h @0x%0h, required no write", bus.mem_wdata, bus.mem_addr);
        end else begin
          exp_wr = sb_q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(exp_wr.addr));
          check("wr_data", 32'(bus.mem_wdata), 32'(exp_wr.data));
        end
      end
    end
    prev_stall = !rst && bus.mem_we && !bus.mem_ready;
    prev_addr  = bus.mem_addr;
    prev_data  = bus.mem_wdata;
  end

  task automatic start_load(input logic [7:0] b);
    base_addr = b;
    start     = 1'b1;
    exp_addr  = b;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last);
    logic got;
    got             = 1'b0;
    bus.in_op       = v.op;
    bus.in_dr       = v.dr;
    bus.in_sr1      = v.sr1;
    bus.in_sr2      = v.sr2;
    bus.in_imm_mode = v.imm_mode;
    bus.in_imm5     = v.imm5;
    bus.in_nzp      = v.nzp;
    bus.in_off9     = v.off9;
    bus.in_last     = last;
    bus.in_valid    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("request_accepted", 32'(got), 32'd1);
    if (got && v.op <= 3'd5) begin
      sb_q.push_back('{exp_addr, v.word});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input logic [7:0] exp_count, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("count_at_done", 32'(count), 32'(exp_count));
      check("err_at_done", 32'(err), 32'(exp_err));
      check("busy_in_done", 32'(busy), 32'd1);
      check("all_writes_seen", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_back_idle", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // op, dr, sr1, sr2, imm_mode, imm5, nzp, off9, expected word
    vecs[0]  = mk(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, 5'h00, 3'b000, 9'h000, 16'h1283);
    vecs[1]  = mk(3'd0, 3'd1, 3'd2, 3'd5, 1'b1, 5'h1F, 3'b000, 9'h000, 16'h12BF);
    vecs[2]  = mk(3'd2, 3'd4, 3'd5, 3'd7, 1'b0, 5'h03, 3'b000, 9'h000, 16'h997F);
    vecs[3]  = mk(3'd3, 3'd7, 3'd0, 3'd0, 1'b0, 5'h00, 3'b010, 9'h1FF, 16'h05FF);
    vecs[4]  = mk(3'd4, 3'd5, 3'd7, 3'd0, 1'b0, 5'h00, 3'b000, 9'h000, 16'hC1C0);
    vecs[5]  = mk(3'd5, 3'd3, 3'd6, 3'd0, 1'b1, 5'h1F, 3'b111, 9'h005, 16'hE605);
    vecs[6]  = mk(3'd1, 3'd0, 3'd0, 3'd0, 1'b1, 5'h00, 3'b000, 9'h000, 16'h5020);
    vecs[7]  = mk(3'd1, 3'd7, 3'd6, 3'd5, 1'b0, 5'h00, 3'b000, 9'h000, 16'h5F85);
    vecs[8]  = mk(3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 5'h00, 3'b000, 9'h0AA, 16'h00AA);
    vecs[9]  = mk(3'd3, 3'd5, 3'd0, 3'd0, 1'b0, 5'h00, 3'b111, 9'h100, 16'h0F00);
    vecs[10] = mk(3'd5, 3'd7, 3'd0, 3'd0, 1'b0, 5'h00, 3'b101, 9'h1FF, 16'hEFFF);
    vecs[11] = mk(3'd0, 3'd0, 3'd7, 3'd0, 1'b1, 5'h10, 3'b000, 9'h000, 16'h11F0);
    bad6     = mk(3'd6, 3'd1, 3'd1, 3'd1, 1'b0, 5'h00, 3'b000, 9'h000, 16'h0000);
    bad7     = mk(3'd7, 3'd2, 3'd2, 3'd2, 1'b1, 5'h01, 3'b001, 9'h001, 16'h0000);

    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_op = 3'd0; bus.in_dr = 3'd0;
    bus.in_sr1 = 3'd0; bus.in_sr2 = 3'd0; bus.in_imm_mode = 1'b0; bus.in_imm5 = 5'h00;
    bus.in_nzp = 3'd0; bus.in_off9 = 9'h000; bus.mem_ready = 1'b1;
    stop_rand = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single ADD register form
    start_load(8'h10);
    send(vecs[0], 1'b1);
    wait_done(8'd1, 1'b0);

    // Whole encoding table as one program
    start_load(8'h00);
    for (int i = 0; i < 12; i++) send(vecs[i], (i == 11));
    wait_done(8'd12, 1'b0);

    // Same table under random write backpressure
    start_load(8'h80);
    fork
      begin
        for (int i = 0; i < 12; i++) send(vecs[i], (i == 11));
        wait_done(8'd12, 1'b0);
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #2;
          bus.mem_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.mem_ready = 1'b1;

    // Stalled memory: four requests fill the FIFO, the fifth waits
    bus.mem_ready = 1'b0;
    start_load(8'h40);
    for (int i = 0; i < 4; i++) send(vecs[i + 1], 1'b0);
    @(negedge clk);
    check("in_ready_when_full", 32'(bus.in_ready), 32'd0);
    check("mem_we_while_stalled", 32'(bus.mem_we), 32'd1);
    check("mem_addr_while_stalled", 32'(bus.mem_addr), 32'h40);
    @(posedge clk); #1;
    fork
      send(vecs[5], 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1 bus.mem_ready = 1'b1;
      end
    join
    wait_done(8'd5, 1'b0);

    // Illegal op in the middle, then an illegal last beat
    start_load(8'h20);
    send(vecs[0], 1'b0);
    send(bad6, 1'b0);
    send(vecs[5], 1'b1);
    wait_done(8'd2, 1'b1);
    @(negedge clk);
    check("err_sticky_in_idle", 32'(err), 32'd1);
    @(posedge clk); #1;
    start_load(8'h30);
    @(negedge clk);
    check("err_cleared_by_start", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(bad7, 1'b1);
    wait_done(8'd0, 1'b1);

    // Address wrap
    start_load(8'hFE);
    for (int i = 0; i < 3; i++) send(vecs[i + 6], (i == 2));
    wait_done(8'd3, 1'b0);
    @(negedge clk);
    check("mem_addr_after_wrap", 32'(bus.mem_addr), 32'h01);
    @(posedge clk); #1;

    // Reset with three words buffered
    bus.mem_ready = 1'b0;
    start_load(8'h60);
    for (int i = 0; i < 3; i++) send(vecs[i + 2], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    bus.mem_ready = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    start_load(8'h70);
    send(vecs[3], 1'b0);
    send(vecs[4], 1'b1);
    wait_done(8'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder/loader for the 16-bit ISA: the inverse of the instruction decoder. It accepts field-level instruction requests over a valid/ready stream, encodes each one into a 16-bit word, buffers it in a small FIFO and writes the words to consecutive instruction-memory addresses. It is used by the boot/test path to place programs in instruction memory before the core runs.

Parameters:
ADDR_W, 8, instruction-memory address width
FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new program load (honoured in IDLE only)
base_addr  input  ADDR_W  first write address, sampled on start
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_op  input  3  0=ADD 1=AND 2=NOT 3=BR 4=JMP 5=LEA 6,7=illegal
in_dr  input  3  destination register
in_sr1  input  3  source 1 / JMP base register
in_sr2  input  3  source 2
in_imm_mode  input  1  ADD/AND immediate select
in_imm5  input  5  ADD/AND immediate
in_nzp  input  3  BR condition bits n,z,p
in_off9  input  9  BR/LEA PC offset
in_last  input  1  final request of the program
mem_we  output  1  write request (= FIFO non-empty)
mem_ready  input  1  memory accepts the write when mem_we && mem_ready
mem_addr  output  ADDR_W  write address
mem_wdata  output  16  encoded word
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at load completion
err  output  1  sticky illegal-op flag
count  output  ADDR_W  words written since start

Behaviour:
- Reset: state IDLE; FIFO empty; in_ready, mem_we, done, err, busy = 0; mem_addr, count, mem_wdata = 0.
- Encoding of word[15:12] | [11:9] | [8:6] | [5:0]:
  - ADD 0001 / AND 0101: dr | sr1 | imm_mode; if imm_mode, [4:0]=imm5; otherwise [4:3]=00 and [2:0]=sr2.
  - NOT 1001: dr | sr1 | 111111.
  - BR 0000: nzp | off9 in [8:0]. nzp=000 is encoded unchanged.
  - JMP 1100: 000 | sr1 | 000000.
  - LEA 1110: dr | off9 in [8:0].
  - Fields that an op does not use are ignored.
- FSM:
  - IDLE: in_ready=0. On start: mem_addr<=base_addr, count<=0, err<=0, go to RUN.
  - RUN: in_ready = !fifo_full. An accepted legal op pushes its encoded word. An accepted illegal op pushes nothing and sets err. An accepted beat with in_last=1 goes to FLUSH, whether the op is legal or not.
  - FLUSH: in_ready=0. Stay until the FIFO is empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- Latency: a word accepted in cycle t appears on mem_we/mem_wdata no earlier than t+1. The FIFO output is registered; there is no bypass path.
- Each write handshake pops the FIFO, increments mem_addr and increments count (both modulo 2^ADDR_W). mem_addr wraps from all-ones to 0 with no error. While mem_ready=0, mem_addr and mem_wdata hold stable.
- Push and pop in the same cycle are allowed when the FIFO is neither full nor empty. Because in_ready depends only on full, a full FIFO blocks input even if a pop happens in that cycle.
- start outside IDLE is ignored. in_valid in IDLE, FLUSH or DONE is ignored.
- rst asserted mid-load discards FIFO contents immediately and returns all outputs to reset values the next cycle. No further mem_we occurs.
- err holds until the next accepted start or rst.

Test Plan:
- start base_addr=0x10, then ADD dr=1,sr1=2,sr2=3,imm_mode=0 with in_last=1, mem_ready=1 -> one write 0x1283 @0x10, then done pulse, count=1, err=0.
- Stream ADD R1,R2,#-1 / NOT R4,R5 / BR nzp=010 off=0x1FF / JMP R7 / LEA R3,off=0x005 / AND R0,R0,#0 (last) from base 0x00 -> writes 0x12BF, 0x997F, 0x05FF, 0xC1C0, 0xE605, 0x5020 at 0x00..0x05; done; count=6.
- Hold mem_ready=0 while issuing 5 requests -> in_ready drops after the 4th accept. Release mem_ready -> all 5 words written in order, with no address or data change while stalled.
- 3 requests with the middle in_op=6 -> err=1, 2 words written at base and base+1. err stays 1 after done and clears on the next start.
- base_addr=0xFE, 3 requests -> addresses 0xFE, 0xFF, 0x00; count=3.
- rst while the FIFO holds 3 words -> next cycle mem_we=0, busy=0, count=0, no further writes. Then start -> normal load.
